// File: rtl/spi_pkg.sv
// Shared widths, FSM state encoding and frame payload for the SPI mode-0 write initiator.
package spi_pkg;

  localparam int unsigned FRAME_W   = 16;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned WR_BIT    = 15;
  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

  // Every request on this link is a write, so the R/W flag is always set.
  function automatic frame_t make_frame(input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] data);
    frame_t f;
    f.wr   = 1'b1;
    f.addr = addr;
    f.data = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Divider that ticks once every CLK_DIV clk cycles; clear restarts the count so the
// first tick lands exactly CLK_DIV cycles after a frame is accepted.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_term;

  assign w_term = (r_cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = w_term;

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write initiator: one 16-bit {W, addr, data} frame per request, MSB first.
// Define SPI_CTRL_READBACK_EN to add CIPO capture of the last 8 bits into rx_data.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              nCS,
  output logic              SCLK,
  output logic              COPI,
  output logic              busy,
`ifdef SPI_CTRL_READBACK_EN
  input  logic              CIPO,
  output logic [DATA_W-1:0] rx_data,
`endif
  output logic              done
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [FRAME_W-1:0]   r_shreg;
  logic [FRAME_W-1:0]   w_shreg_nxt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [BIT_CNT_W-1:0] w_bit_cnt_nxt;
  logic                 r_high;
  logic                 w_high_nxt;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [GAP_W-1:0]     w_gap_cnt_nxt;

  logic r_ncs,   w_ncs_nxt;
  logic r_sclk,  w_sclk_nxt;
  logic r_copi,  w_copi_nxt;
  logic r_ready, w_ready_nxt;
  logic r_busy,  w_busy_nxt;
  logic r_done,  w_done_nxt;

  frame_t             w_frame;
  logic [FRAME_W-1:0] w_frame_bits;
  logic               w_accept;
  logic               w_tick;

  assign w_frame      = make_frame(req_addr, req_data);
  assign w_frame_bits = w_frame;
  assign w_accept     = (r_state == IDLE) && req_valid && r_ready;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .clear(w_accept),
    .tick (w_tick)
  );

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_high_nxt    = r_high;
    w_gap_cnt_nxt = r_gap_cnt;
    w_ncs_nxt     = r_ncs;
    w_sclk_nxt    = r_sclk;
    w_copi_nxt    = r_copi;
    w_ready_nxt   = r_ready;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt   = SETUP;
          w_shreg_nxt   = w_frame_bits;
          w_bit_cnt_nxt = BIT_CNT_W'(FRAME_W - 1);
          w_high_nxt    = 1'b0;
          w_ncs_nxt     = 1'b0;
          w_sclk_nxt    = 1'b0;
          w_copi_nxt    = w_frame_bits[WR_BIT];
          w_ready_nxt   = 1'b0;
          w_busy_nxt    = 1'b1;
        end
      end

      SETUP: begin
        if (w_tick) begin
          w_state_nxt = SHIFT;
        end
      end

      // COPI only moves on the falling edge, so it is stable across every rise.
      SHIFT: begin
        if (w_tick) begin
          if (!r_high) begin
            w_sclk_nxt = 1'b1;
            w_high_nxt = 1'b1;
          end else begin
            w_sclk_nxt = 1'b0;
            w_high_nxt = 1'b0;
            if (r_bit_cnt == '0) begin
              w_state_nxt = HOLD;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt - BIT_CNT_W'(1);
              w_shreg_nxt   = {r_shreg[FRAME_W-2:0], 1'b0};
              w_copi_nxt    = r_shreg[FRAME_W-2];
            end
          end
        end
      end

      HOLD: begin
        if (w_tick) begin
          w_state_nxt   = GAP;
          w_ncs_nxt     = 1'b1;
          w_copi_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_gap_cnt_nxt = '0;
        end
      end

      GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = IDLE;
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_high    <= 1'b0;
      r_gap_cnt <= '0;
      r_ncs     <= 1'b1;
      r_sclk    <= 1'b0;
      r_copi    <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_high    <= w_high_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_ncs     <= w_ncs_nxt;
      r_sclk    <= w_sclk_nxt;
      r_copi    <= w_copi_nxt;
      r_ready   <= w_ready_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

`ifdef SPI_CTRL_READBACK_EN
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] w_rx_sh_nxt;
  logic [DATA_W-1:0] r_rx_data;
  logic [DATA_W-1:0] w_rx_data_nxt;
  logic              w_rise;

  assign w_rise = (r_state == SHIFT) && w_tick && !r_high;

  // Capture only the data byte (bits 7..0) on the edges that raise SCLK.
  always_comb begin
    w_rx_sh_nxt   = r_rx_sh;
    w_rx_data_nxt = r_rx_data;
    if (w_accept) begin
      w_rx_sh_nxt = '0;
    end else if (w_rise && (r_bit_cnt < BIT_CNT_W'(DATA_W))) begin
      w_rx_sh_nxt = {r_rx_sh[DATA_W-2:0], CIPO};
    end
    if (w_done_nxt) begin
      w_rx_data_nxt = r_rx_sh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_sh   <= '0;
      r_rx_data <= '0;
    end else begin
      r_rx_sh   <= w_rx_sh_nxt;
      r_rx_data <= w_rx_data_nxt;
    end
  end

  assign rx_data = r_rx_data;
`endif

  assign req_ready = r_ready;
  assign nCS       = r_ncs;
  assign SCLK      = r_sclk;
  assign COPI      = r_copi;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: two instances (CLK_DIV=4 and CLK_DIV=1) share clk/rst.
`timescale 1ns/1ps
module tb_spi_controller;

  localparam int unsigned GAP = 8;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  pat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       valid4, ready4, ncs4, sclk4, copi4, busy4, done4;
  logic       valid1, ready1, ncs1, sclk1, copi1, busy1, done1;
  logic [6:0] addr4, addr1;
  logic [7:0] data4, data1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q0[$];
  exp_t q1[$];
  int   exp_done[2];

  // Monitor state, written only by the monitor process.
  int          rises[2];
  int          low_len[2];
  int          high_len[2];
  int          done_seen[2];
  logic [15:0] shv[2];
  logic [7:0]  cur_pat[2];
  logic [7:0]  last_pat[2];
  bit          in_frame[2];
  bit          hold_chk[2];
  logic        p_ncs[2];
  logic        p_sclk[2];
  logic        p_rst;
  logic        c_ncs, c_sclk, c_copi, c_done, c_ready, c_busy;
  logic [7:0]  c_rx;
  exp_t        e;

`ifdef SPI_CTRL_READBACK_EN
  logic       cipo4, cipo1;
  logic [7:0] rx4, rx1;
  // Peripheral model: present the expected byte during bits 7..0, stable across each rise.
  always_comb begin
    cipo4 = 1'b0;
    cipo1 = 1'b0;
    if (in_frame[0] && rises[0] >= 8 && rises[0] < 16) cipo4 = cur_pat[0][15 - rises[0]];
    if (in_frame[1] && rises[1] >= 8 && rises[1] < 16) cipo1 = cur_pat[1][15 - rises[1]];
  end
`endif

  spi_controller #(.CLK_DIV(4), .GAP_CYCLES(GAP)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(valid4), .req_ready(ready4),
    .req_addr(addr4), .req_data(data4), .nCS(ncs4), .SCLK(sclk4), .COPI(copi4),
    .busy(busy4),
`ifdef SPI_CTRL_READBACK_EN
    .CIPO(cipo4), .rx_data(rx4),
`endif
    .done(done4)
  );

  spi_controller #(.CLK_DIV(1), .GAP_CYCLES(GAP)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(ready1),
    .req_addr(addr1), .req_data(data1), .nCS(ncs1), .SCLK(sclk1), .COPI(copi1),
    .busy(busy1),
`ifdef SPI_CTRL_READBACK_EN
    .CIPO(cipo1), .rx_data(rx1),
`endif
    .done(done1)
  );

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, i, act, exp, cyc);
    end
  endtask

  // Monitor: rebuilds each frame from COPI at SCLK rises and scores it at nCS rise.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      c_ncs   = (i == 0) ? ncs4   : ncs1;
      c_sclk  = (i == 0) ? sclk4  : sclk1;
      c_copi  = (i == 0) ? copi4  : copi1;
      c_done  = (i == 0) ? done4  : done1;
      c_ready = (i == 0) ? ready4 : ready1;
      c_busy  = (i == 0) ? busy4  : busy1;
`ifdef SPI_CTRL_READBACK_EN
      c_rx    = (i == 0) ? rx4    : rx1;
`else
      c_rx    = 8'h00;
`endif
      if (rst) begin
        in_frame[i] = 1'b0;
        hold_chk[i] = 1'b0;
        rises[i]    = 0;
        if (p_rst)
          check("reset_outputs", i, {26'd0, c_ncs, c_sclk, c_copi, c_ready, c_busy, c_done},
                {26'd0, 6'b100100});
      end else begin
        check("done_align", i, {31'd0, c_done}, {31'd0, (!p_ncs[i] && c_ncs)});
        if (c_done) done_seen[i]++;
        if (c_ncs) check("sclk_idle", i, {31'd0, c_sclk}, 32'd0);
        if (hold_chk[i]) begin
          check("rx_hold", i, {24'd0, c_rx}, {24'd0, last_pat[i]});
          hold_chk[i] = 1'b0;
        end
        if (p_ncs[i] && !c_ncs) begin
          in_frame[i] = 1'b1;
          rises[i]    = 0;
          shv[i]      = '0;
          low_len[i]  = 1;
          if (i == 0) cur_pat[i] = (q0.size() > 0) ? q0[0].pat : 8'h00;
          else        cur_pat[i] = (q1.size() > 0) ? q1[0].pat : 8'h00;
        end else if (!c_ncs) begin
          low_len[i]++;
        end
        if (in_frame[i]) begin
          if (c_sclk && !p_sclk[i]) begin
            rises[i]++;
            shv[i]      = {shv[i][14:0], c_copi};
            high_len[i] = 0;
          end
          if (c_sclk) high_len[i]++;
          if (!c_sclk && p_sclk[i])
            check("sclk_high_len", i, high_len[i], (i == 0) ? 32'd4 : 32'd1);
        end
        if (!p_ncs[i] && c_ncs && in_frame[i]) begin
          in_frame[i] = 1'b0;
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            check("unexpected_frame", i, 32'd1, 32'd0);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            check("frame", i, {16'd0, shv[i]}, {16'd0, e.frame});
            check("rise_count", i, rises[i], 32'd16);
            check("ncs_low_len", i, low_len[i], (i == 0) ? 32'd136 : 32'd34);
            check("done_at_ncs_rise", i, {31'd0, c_done}, 32'd1);
`ifdef SPI_CTRL_READBACK_EN
            check("rx_data", i, {24'd0, c_rx}, {24'd0, e.pat});
            last_pat[i] = e.pat;
            hold_chk[i] = 1'b1;
`endif
          end
        end
      end
      p_ncs[i]  = c_ncs;
      p_sclk[i] = c_sclk;
    end
    p_rst = rst;
  end

  // Issue one request; called at #1 after a posedge, returns at #1 after the accepting edge.
  task automatic send(input int i, input logic [6:0] a, input logic [7:0] d, input logic [7:0] p,
                      input bit push, input bit keep_valid, output int acc_cyc);
    int   budget;
    logic rdy;
    exp_t x;
    budget = 0;
    if (i == 0) begin valid4 = 1'b1; addr4 = a; data4 = d; end
    else        begin valid1 = 1'b1; addr1 = a; data1 = d; end
    rdy = (i == 0) ? ready4 : ready1;
    while (!rdy && budget < 2000) begin
      @(posedge clk); #1;
      budget++;
      rdy = (i == 0) ? ready4 : ready1;
    end
    acc_cyc = -1;
    if (!rdy) begin
      check("accept_timeout", i, 32'd0, 32'd1);
    end else begin
      if (push) begin
        x.frame = {1'b1, a, d};
        x.pat   = p;
        if (i == 0) q0.push_back(x); else q1.push_back(x);
        exp_done[i]++;
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
      if (i == 0) check("accept_outputs", i, {29'd0, ready4, busy4, ncs4}, 32'b010);
      else        check("accept_outputs", i, {29'd0, ready1, busy1, ncs1}, 32'b010);
    end
    if (!keep_valid) begin
      if (i == 0) valid4 = 1'b0; else valid1 = 1'b0;
    end
  endtask

  task automatic wait_idle(input int i);
    int budget;
    budget = 0;
    while (((i == 0) ? busy4 : busy1) && budget < 2000) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 2000) check("idle_timeout", i, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, tmp, budget;
    rst = 1'b1;
    valid4 = 1'b0; addr4 = '0; data4 = '0;
    valid1 = 1'b0; addr1 = '0; data1 = '0;
    p_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_ncs[i] = 1'b1; p_sclk[i] = 1'b0; in_frame[i] = 1'b0; hold_chk[i] = 1'b0;
      rises[i] = 0; low_len[i] = 0; high_len[i] = 0; done_seen[i] = 0; exp_done[i] = 0;
      shv[i] = '0; cur_pat[i] = '0; last_pat[i] = '0;
    end
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: outputs sit at reset values.
    repeat (20) begin
      @(posedge clk); #1;
      check("idle", 0, {26'd0, ncs4, sclk4, copi4, ready4, busy4, done4}, {26'd0, 6'b100100});
      check("idle", 1, {26'd0, ncs1, sclk1, copi1, ready1, busy1, done1}, {26'd0, 6'b100100});
    end

    // Directed single write, CLK_DIV=4.
    send(0, 7'h04, 8'hA5, 8'hC3, 1'b1, 1'b0, tmp);
    wait_idle(0);

    // Back-to-back with req_valid held high.
    send(0, 7'h01, 8'hFF, 8'h3C, 1'b1, 1'b1, t1);
    send(0, 7'h7F, 8'h00, 8'h96, 1'b1, 1'b0, t2);
    check("b2b_period", 0, t2 - t1, 34 * 4 + GAP + 1);
    wait_idle(0);

    // Reset after the 5th SCLK rise; that frame is abandoned.
    send(0, 7'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b0, tmp);
    budget = 0;
    while (rises[0] < 5 && budget < 500) begin
      @(posedge clk); #1;
      budget++;
    end
    check("reach_5th_rise", 0, {31'd0, rises[0] >= 5}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_frame_reset", 0, {27'd0, ncs4, sclk4, ready4, busy4, done4}, {27'd0, 5'b10100});
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(0, 7'h12, 8'h34, 8'h5A, 1'b1, 1'b0, tmp);
    wait_idle(0);

    // CLK_DIV=1 with inputs scrambled while the frame is in flight.
    send(1, 7'h2A, 8'h5A, 8'hE7, 1'b1, 1'b0, tmp);
    budget = 0;
    while (busy1 && budget < 200) begin
      addr1 = 7'($urandom);
      data1 = 8'($urandom);
      @(posedge clk); #1;
      budget++;
    end

    // Randomized requests to either instance, random idle gaps.
    for (int k = 0; k < 8; k++) begin
      send(int'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
           1'b1, 1'b0, tmp);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    wait_idle(0);
    wait_idle(1);
    repeat (4) begin @(posedge clk); #1; end

    check("done_count", 0, done_seen[0], exp_done[0]);
    check("done_count", 1, done_seen[1], exp_done[1]);
    check("queue_drained", 0, q0.size(), 32'd0);
    check("queue_drained", 1, q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
